// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Register file with a per-register busy (pending) bit, combinational
//   reads and a sequential whole-file clear that walks one register per
//   cycle. Register 0 can be hardwired to zero.
//
//   Optional feature, selected at compile time:
//     REG_BYPASS_EN  - when defined, a write in IDLE is forwarded to any
//                      read port addressing the same register in the same
//                      cycle (data = write data, busy = 0). When undefined,
//                      reads only ever see stored contents.
//
//   Parameters: DEPTH must equal 2**SELECTOR.
module reg_file_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int SELECTOR = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Reg_Write_i,
  input  logic [SELECTOR-1:0] Write_Register_i,
  input  logic [WIDTH-1:0]    Write_Data_i,
  input  logic [SELECTOR-1:0] Read_Register_1_i,
  input  logic [SELECTOR-1:0] Read_Register_2_i,
  input  logic                Reserve_i,
  input  logic [SELECTOR-1:0] Reserve_Register_i,
  input  logic                Clear_i,
  output logic [WIDTH-1:0]    Read_Data_1_o,
  output logic [WIDTH-1:0]    Read_Data_2_o,
  output logic                Busy_1_o,
  output logic                Busy_2_o,
  output logic                Ready_o,
  output logic                Clear_Done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [SELECTOR-1:0] clr_idx, clr_idx_next;

  logic [WIDTH-1:0]    regs [DEPTH];
  logic [DEPTH-1:0]    busy;

  logic                idle;
  logic                clearing;
  logic                clr_last;
  logic                wr_ok;
  logic                rsv_ok;
  logic                wr_en;
  logic                rsv_en;

  assign idle     = (state == IDLE);
  assign clearing = (state == CLEAR);
  assign clr_last = (clr_idx == SELECTOR'(DEPTH - 1));

  // Register 0 is untouchable when hardwired; it then keeps its reset zero
  // and its busy bit never sets.
  assign wr_ok  = (ZERO_REG == 0) || (Write_Register_i != '0);
  assign rsv_ok = (ZERO_REG == 0) || (Reserve_Register_i != '0);

  // Writes and reserves are only accepted in IDLE; CLEAR and DONE drop them.
  assign wr_en  = idle && Reg_Write_i && wr_ok;
  assign rsv_en = idle && Reserve_i && rsv_ok;

  // State register and clear-index counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= next_state;
      clr_idx <= clr_idx_next;
    end
  end

  // Next-state, counter advance and status outputs.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    clr_idx_next = clr_idx;
    Ready_o      = 1'b1;
    Clear_Done_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (Clear_i) begin
          next_state   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        Ready_o = 1'b0;
        if (clr_last) begin
          next_state   = DONE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + 1'b1;
        end
      end
      DONE: begin
        // Clear_i is deliberately not looked at here.
        Clear_Done_o = 1'b1;
        next_state   = IDLE;
      end
      default: begin
        next_state   = IDLE;
        clr_idx_next = '0;
      end
    endcase
  end

  // Register contents and busy bits: clear walk, write, reserve.
  // NOTE: the storage array is reset on purpose -- reset must zero every
  // register at once, which rules out a plain RAM macro here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else if (clearing) begin
      regs[clr_idx] <= '0;
      busy[clr_idx] <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[Write_Register_i] <= Write_Data_i;
        busy[Write_Register_i] <= 1'b0;
      end
      // Placed after the write so a same-index reserve overrides the
      // busy clear from the write.
      if (rsv_en) begin
        busy[Reserve_Register_i] <= 1'b1;
      end
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    Read_Data_1_o = regs[Read_Register_1_i];
    Read_Data_2_o = regs[Read_Register_2_i];
    Busy_1_o      = busy[Read_Register_1_i];
    Busy_2_o      = busy[Read_Register_2_i];
`ifdef REG_BYPASS_EN
    if (wr_en && (Read_Register_1_i == Write_Register_i)) begin
      Read_Data_1_o = Write_Data_i;
      Busy_1_o      = 1'b0;
    end
    if (wr_en && (Read_Register_2_i == Write_Register_i)) begin
      Read_Data_2_o = Write_Data_i;
      Busy_2_o      = 1'b0;
    end
`else
    // Stored contents only: a write becomes visible after its edge.
`endif
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Testbench for reg_file_scoreboard (default parameters).
// A behavioural model tracks the expected file contents and clear progress;
// a negedge process compares every output against it each cycle, and the
// directed sequence adds hand-computed literal checks.
module tb_reg_file_scoreboard;

  localparam int W = 32;
  localparam int S = 5;
  localparam int D = 32;

  logic         clk;
  logic         rst;
  logic         Reg_Write_i;
  logic [S-1:0] Write_Register_i;
  logic [W-1:0] Write_Data_i;
  logic [S-1:0] Read_Register_1_i;
  logic [S-1:0] Read_Register_2_i;
  logic         Reserve_i;
  logic [S-1:0] Reserve_Register_i;
  logic         Clear_i;
  logic [W-1:0] Read_Data_1_o;
  logic [W-1:0] Read_Data_2_o;
  logic         Busy_1_o;
  logic         Busy_2_o;
  logic         Ready_o;
  logic         Clear_Done_o;

  int total = 0;
  int bad   = 0;

  reg_file_scoreboard #(
    .WIDTH(W), .DEPTH(D), .SELECTOR(S), .ZERO_REG(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Reserve_i         (Reserve_i),
    .Reserve_Register_i(Reserve_Register_i),
    .Clear_i           (Clear_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o),
    .Busy_1_o          (Busy_1_o),
    .Busy_2_o          (Busy_2_o),
    .Ready_o           (Ready_o),
    .Clear_Done_o      (Clear_Done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_regs [D];
  logic         m_busy [D];
  int           clr_left;   // cycles of clearing still to run (0 = not clearing)
  int           clr_pos;    // next register the clear will zero
  logic         done_phase; // the one cycle after the clear finishes
  logic         cmp_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
      clr_left   <= 0;
      clr_pos    <= 0;
      done_phase <= 1'b0;
    end else if (clr_left != 0) begin
      m_regs[clr_pos] <= '0;
      m_busy[clr_pos] <= 1'b0;
      clr_pos         <= clr_pos + 1;
      clr_left        <= clr_left - 1;
      if (clr_left == 1) done_phase <= 1'b1;
    end else if (done_phase) begin
      done_phase <= 1'b0;
    end else begin
      if (Clear_i) begin
        clr_left <= D;
        clr_pos  <= 0;
      end
      if (Reg_Write_i && Write_Register_i != 0) begin
        m_regs[Write_Register_i] <= Write_Data_i;
        m_busy[Write_Register_i] <= 1'b0;
      end
      if (Reserve_i && Reserve_Register_i != 0) m_busy[Reserve_Register_i] <= 1'b1;
    end
  end

  function automatic logic [W:0] model_read(input logic [S-1:0] idx);
    logic [W-1:0] d;
    logic         b;
    d = m_regs[idx];
    b = m_busy[idx];
`ifdef REG_BYPASS_EN
    if (clr_left == 0 && !done_phase && Reg_Write_i && Write_Register_i != 0 &&
        Write_Register_i == idx) begin
      d = Write_Data_i;
      b = 1'b0;
    end
`endif
    return {b, d};
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [W:0] e1, e2;
      e1 = model_read(Read_Register_1_i);
      e2 = model_read(Read_Register_2_i);
      check("cyc_rd1",   Read_Data_1_o, e1[W-1:0]);
      check("cyc_rd2",   Read_Data_2_o, e2[W-1:0]);
      check("cyc_busy1", Busy_1_o, e1[W]);
      check("cyc_busy2", Busy_2_o, e2[W]);
      check("cyc_ready", Ready_o, clr_left == 0);
      check("cyc_done",  Clear_Done_o, done_phase);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    Reg_Write_i        = 1'b0;
    Write_Register_i   = '0;
    Write_Data_i       = '0;
    Reserve_i          = 1'b0;
    Reserve_Register_i = '0;
    Clear_i            = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [S-1:0] idx, input logic [W-1:0] data);
    Reg_Write_i      = 1'b1;
    Write_Register_i = idx;
    Write_Data_i     = data;
  endtask

  int low_cnt;
  int done_cnt;

  initial begin
    cmp_en = 1'b0;
    rst    = 1'b0;
    idle_inputs();
    Read_Register_1_i = 5'd5;
    Read_Register_2_i = 5'd7;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    step();
    step();
    // Reset state
    check("rst_ready", Ready_o, 1'b1);
    check("rst_done",  Clear_Done_o, 1'b0);
    check("rst_data",  Read_Data_1_o, 32'h0);
    check("rst_busy",  Busy_2_o, 1'b0);
    rst = 1'b0;
    step();

    // Write r5, read next cycle
    write_reg(5'd5, 32'hDEADBEEF);
    step();
    idle_inputs();
    Read_Register_1_i = 5'd5;
    #1;
    check("r5_data", Read_Data_1_o, 32'hDEADBEEF);
    check("r5_busy", Busy_1_o, 1'b0);

    // Register 0 ignores write and reserve
    write_reg(5'd0, 32'h12345678);
    Reserve_i          = 1'b1;
    Reserve_Register_i = 5'd0;
    step();
    idle_inputs();
    Read_Register_1_i = 5'd0;
    #1;
    check("r0_data", Read_Data_1_o, 32'h0);
    check("r0_busy", Busy_1_o, 1'b0);

    // Reserve r7, write it two cycles later
    Reserve_i          = 1'b1;
    Reserve_Register_i = 5'd7;
    step();
    idle_inputs();
    Read_Register_2_i = 5'd7;
    #1 check("r7_busy_gap1", Busy_2_o, 1'b1);
    step();
    check("r7_busy_gap2", Busy_2_o, 1'b1);
    write_reg(5'd7, 32'hA5);
    step();
    idle_inputs();
    #1;
    check("r7_busy_after", Busy_2_o, 1'b0);
    check("r7_data_after", Read_Data_2_o, 32'hA5);
    // Same-cycle write and reserve: reserve wins on busy, data stored
    write_reg(5'd7, 32'h11);
    Reserve_i          = 1'b1;
    Reserve_Register_i = 5'd7;
    step();
    idle_inputs();
    #1;
    check("r7_wr_rsv_busy", Busy_2_o, 1'b1);
    check("r7_wr_rsv_data", Read_Data_2_o, 32'h11);

    // Fill r1..r31 and clear the whole file
    for (int i = 1; i < D; i++) begin
      write_reg(S'(i), 32'h01010101 * i);
      step();
    end
    idle_inputs();
    Read_Register_1_i = 5'd31;
    #1 check("fill_r31", Read_Data_1_o, 32'h1F1F1F1F);
    Clear_i = 1'b1;
    step();
    Clear_i  = 1'b0;
    low_cnt  = 0;
    done_cnt = 0;
    Read_Register_1_i = 5'd2;
    for (int k = 0; k < 40; k++) begin
      Clear_i      = (k == 3);           // ignored while clearing
      Reg_Write_i  = (k == 5);           // lost: r2 is already cleared
      Write_Register_i = 5'd2;
      Write_Data_i = 32'hFFFF0000;
      #1;
      if (!Ready_o) low_cnt++;
      if (Clear_Done_o) begin
        done_cnt++;
        Clear_i = 1'b1;                  // ignored in DONE
      end
      step();
    end
    idle_inputs();
    check("clr_ready_low_cycles", low_cnt, 32);
    check("clr_done_pulses", done_cnt, 1);
    check("clr_ready_after", Ready_o, 1'b1);
    for (int i = 0; i < D; i++) begin
      Read_Register_1_i = S'(i);
      #1 check("clr_all_zero", Read_Data_1_o, 32'h0);
    end

    // Same-cycle write and read of r3
    write_reg(5'd3, 32'h33);
    step();
    write_reg(5'd3, 32'h55);
    Read_Register_1_i = 5'd3;
    #1;
`ifdef REG_BYPASS_EN
    check("bypass_same_cycle", Read_Data_1_o, 32'h55);
`else
    check("bypass_same_cycle", Read_Data_1_o, 32'h33);
`endif
    step();
    idle_inputs();
    #1 check("bypass_next_cycle", Read_Data_1_o, 32'h55);

    // Reset in the middle of a clear
    write_reg(5'd20, 32'h20);
    step();
    write_reg(5'd15, 32'h15);
    step();
    idle_inputs();
    Clear_i = 1'b1;
    step();
    Clear_i = 1'b0;
    repeat (10) step();                  // indices 0..9 cleared, 10 next
    Read_Register_1_i = 5'd20;
    Read_Register_2_i = 5'd15;
    #1 check("midclr_ready_low", Ready_o, 1'b0);
    rst = 1'b1;
    #1;
    check("midclr_rst_ready", Ready_o, 1'b1);
    check("midclr_rst_done",  Clear_Done_o, 1'b0);
    check("midclr_rst_r20",   Read_Data_1_o, 32'h0);
    check("midclr_rst_r15",   Read_Data_2_o, 32'h0);
    step();
    rst      = 1'b0;
    low_cnt  = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!Ready_o) low_cnt++;
      if (Clear_Done_o) done_cnt++;
      step();
    end
    check("midclr_no_done", done_cnt, 0);
    check("midclr_idle",    low_cnt, 0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers.
REQ-003 SHALL have parameter SELECTOR, default 5: register-index width; DEPTH SHALL equal 2**SELECTOR.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 hardwires register 0 to zero.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port Reg_Write_i, input, 1: write enable.
REQ-008 SHALL have port Write_Register_i, input, SELECTOR: write index.
REQ-009 SHALL have port Write_Data_i, input, WIDTH: write data.
REQ-010 SHALL have ports Read_Register_1_i and Read_Register_2_i, input, SELECTOR each: read indices.
REQ-011 SHALL have port Reserve_i, input, 1: mark a register pending (busy).
REQ-012 SHALL have port Reserve_Register_i, input, SELECTOR: index to reserve.
REQ-013 SHALL have port Clear_i, input, 1: start a sequential clear of the whole file.
REQ-014 SHALL have ports Read_Data_1_o and Read_Data_2_o, output, WIDTH each: read data.
REQ-015 SHALL have ports Busy_1_o and Busy_2_o, output, 1 each: busy bit of the selected read register.
REQ-016 SHALL have port Ready_o, output, 1: high when not clearing.
REQ-017 SHALL have port Clear_Done_o, output, 1: one-cycle pulse when a clear completes.

Function
REQ-018 Reads SHALL be combinational, with zero-cycle latency from index to data/busy.
REQ-019 Reg_Write_i=1 in IDLE SHALL store Write_Data_i into Write_Register_i and clear its busy bit at the next edge.
REQ-020 Reserve_i=1 in IDLE SHALL set busy[Reserve_Register_i] at the next edge.
REQ-021 Simultaneous write and reserve of the same index SHALL store the data and leave busy=1 (reserve wins).
REQ-022 With ZERO_REG=1, register 0 SHALL ignore writes and reserves, read 0 and report busy 0.
REQ-023 FSM states SHALL be IDLE, CLEAR, DONE.
REQ-024 IDLE->CLEAR on Clear_i=1; the index counter SHALL start at 0.
REQ-025 In CLEAR, each cycle SHALL zero register[counter] and its busy bit, then increment the counter.
REQ-026 CLEAR->DONE after index DEPTH-1; clear SHALL take exactly DEPTH cycles.
REQ-027 DONE SHALL last one cycle, with Clear_Done_o=1, then return to IDLE.
REQ-028 Ready_o SHALL be 0 in CLEAR and 1 in IDLE and DONE.
REQ-029 In CLEAR, Reg_Write_i, Reserve_i and Clear_i SHALL be ignored; reads SHALL return current contents.
REQ-030 Clear_i asserted in DONE SHALL be ignored; Clear_i in IDLE SHALL be honoured on every request.
REQ-031 Busy_n_o SHALL reflect the stored busy bit before the edge, subject to REQ-034.

Reset
REQ-032 rst=1 SHALL immediately zero all registers and busy bits, force IDLE and counter 0, and drive Ready_o=1 and Clear_Done_o=0.
REQ-033 rst asserted mid-CLEAR SHALL abort the clear; the block SHALL resume in IDLE with no Clear_Done_o pulse.

Configuration
REQ-034 Macro REG_BYPASS_EN defined: in IDLE, if Reg_Write_i=1 and Read_Register_n_i equals a writable Write_Register_i, then Read_Data_n_o SHALL equal Write_Data_i and Busy_n_o SHALL be 0 in the same cycle.
REQ-035 Macro REG_BYPASS_EN undefined: reads SHALL return stored values only, so written data becomes visible the cycle after the write edge.

Verification
REQ-036 Write 0xDEADBEEF to r5, read r5 next cycle -> Read_Data_1_o=0xDEADBEEF, Busy_1_o=0.
REQ-037 Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0x00000000; reserve r0 -> Busy 0.
REQ-038 Reserve r7, then write 0xA5 to r7 two cycles later -> Busy=1 during the gap, then 0 and data 0xA5; a same-cycle write and reserve of r7 -> busy stays 1.
REQ-039 Fill r1..r31 with nonzero values, pulse Clear_i -> Ready_o low for 32 cycles, Clear_Done_o high for 1 cycle, all reads 0; a write attempted during CLEAR is lost.
REQ-040 Write 0x55 to r3 while reading r3 in the same cycle -> 0x55 immediately with REG_BYPASS_EN, old value without it.
REQ-041 Assert rst at clear index 10 -> IDLE immediately, all registers 0, no Clear_Done_o pulse.
